// File: rtl/rle_pkg.sv
// Shared types for the line RLE encoder/decoder pair: descriptor record, FSM states and clamp helper.
package rle_pkg;

  localparam int RUN_W = 11;
  localparam logic [RUN_W-1:0] DEF_IMAGE_W = 11'd639;

  typedef struct packed {
    logic [RUN_W-1:0] s1;
    logic [RUN_W-1:0] s2;
    logic [RUN_W-1:0] s3;
  } rle_desc_t;

  typedef enum logic [1:0] {IDLE, BLK_L, WHT, BLK_R} rle_state_t;

  function automatic logic [RUN_W:0] min_len(input logic [RUN_W:0] a, input logic [RUN_W:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/rle_desc_fifo.sv
// Small descriptor FIFO; a push into a full FIFO is legal when a pop happens in the same cycle.
module rle_desc_fifo
  import rle_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      push,
  input  rle_desc_t wdata,
  input  logic      pop,
  output rle_desc_t head,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  rle_desc_t       mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // NOTE: storage is not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/rle_line_decoder.sv
// Expands {left black, white, right black} line descriptors into a 1-bit pixel stream,
// one pixel per enable, with a small descriptor buffer so the next line can queue up.
module rle_line_decoder
  import rle_pkg::*;
#(
  parameter logic [RUN_W-1:0] IMAGE_W = DEF_IMAGE_W,
  parameter int               FIFO_D  = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [RUN_W-1:0] stream1,
  input  logic [RUN_W-1:0] stream2,
  input  logic [RUN_W-1:0] stream3,
  input  logic             desc_valid,
  output logic             desc_ready,
  input  logic             enable,
  output logic             pixelout,
  output logic             pix_valid,
  output logic             line_start,
  output logic             line_end,
  output logic             underrun,
  output logic             overflow,
  output logic             len_err
);

  localparam logic [RUN_W:0] LINE_LEN = (RUN_W+1)'(IMAGE_W) + (RUN_W+1)'(1);

  rle_desc_t        head;
  logic             full, empty, push, pop;
  rle_state_t       state, state_next, run;
  logic [RUN_W-1:0] idx, idx_next, cnt, cnt_next, run_cnt;
  logic [RUN_W:0]   l_len, w_len, sum;
  logic             fire, start, last;

  rle_desc_fifo #(.DEPTH(FIFO_D)) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push),
    .wdata ('{s1: stream1, s2: stream2, s3: stream3}),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  // Head stays in place until its last pixel pops it, so it serves as the loaded descriptor.
  assign l_len = min_len({1'b0, head.s1}, LINE_LEN);
  assign w_len = min_len({1'b0, head.s2}, LINE_LEN - l_len);
  assign sum   = {1'b0, head.s1} + {1'b0, head.s2} + {1'b0, head.s3};

  assign fire       = enable && !(state == IDLE && empty);
  assign start      = fire && (state == IDLE);
  assign last       = fire && (idx == IMAGE_W);
  assign pop        = last;
  assign desc_ready = !full || pop;
  assign push       = desc_valid && desc_ready;

  // NOTE: every variable gets a default at the top so no path leaves one unassigned (no latch).
  always_comb begin
    run        = (state == IDLE) ? BLK_L : state;
    run_cnt    = (state == IDLE) ? '0 : cnt;
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    // Exhausted (including zero-length) runs fall through in the same cycle.
    if (run == BLK_L && {1'b0, run_cnt} >= l_len) begin
      run     = WHT;
      run_cnt = '0;
    end
    if (run == WHT && {1'b0, run_cnt} >= w_len) begin
      run     = BLK_R;
      run_cnt = '0;
    end
    if (fire) begin
      state_next = last ? IDLE : run;
      cnt_next   = run_cnt + RUN_W'(1);
      idx_next   = last ? '0 : idx + RUN_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pixelout   <= 1'b0;
      pix_valid  <= 1'b0;
      line_start <= 1'b0;
      line_end   <= 1'b0;
      underrun   <= 1'b0;
      overflow   <= 1'b0;
      len_err    <= 1'b0;
    end else begin
      pix_valid  <= fire;
      line_start <= start;
      line_end   <= last;
      len_err    <= start && (sum > LINE_LEN);
      underrun   <= enable && (state == IDLE) && empty;
      overflow   <= desc_valid && !desc_ready;
      if (fire) pixelout <= (run == WHT);
    end
  end

endmodule

// File: tb/tb_rle_line_decoder.sv
// Directed bench for rle_line_decoder: vector table of single lines plus hand sequences for
// overflow/back-to-back, 50% enable duty, underrun and mid-line reset.
module tb_rle_line_decoder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [10:0] stream1 = '0, stream2 = '0, stream3 = '0;
  logic        desc_valid = 1'b0;
  logic        enable = 1'b0;
  logic        desc_ready, pixelout, pix_valid, line_start, line_end, underrun, overflow, len_err;

  always #5 CLK = ~CLK;

  rle_line_decoder dut (
    .CLK        (CLK),
    .RST        (RST),
    .stream1    (stream1),
    .stream2    (stream2),
    .stream3    (stream3),
    .desc_valid (desc_valid),
    .desc_ready (desc_ready),
    .enable     (enable),
    .pixelout   (pixelout),
    .pix_valid  (pix_valid),
    .line_start (line_start),
    .line_end   (line_end),
    .underrun   (underrun),
    .overflow   (overflow),
    .len_err    (len_err)
  );

  typedef struct {
    logic [10:0] s1, s2, s3;
    int          first;
    int          nones;
    logic        lerr;
  } vec_t;

  vec_t vecs [7];
  vec_t vb, vfresh;
  int   n_cmp = 0, n_bad = 0;
  int   base, lb;

  // Monitor: records every valid pixel and tracks line position for framing flags.
  bit   px_q [$];
  bit   lerr_q [$];
  int   pos = 0, pos_bad = 0, gap = 0, stray = 0;
  logic en_q;

  always @(posedge CLK) begin
    en_q = enable;
    #1;
    if (RST) pos = 0;
    else begin
      if (pix_valid) begin
        px_q.push_back(pixelout);
        if (line_start !== (pos == 0))   pos_bad++;
        if (line_end   !== (pos == 639)) pos_bad++;
        if (pos == 0) lerr_q.push_back(len_err);
        else if (len_err) pos_bad++;
        pos = (pos == 639) ? 0 : pos + 1;
      end else if (line_start || line_end || len_err) pos_bad++;
      if (!en_q && pix_valid) stray++;
      if (en_q && !pix_valid && !underrun) gap++;
    end
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [10:0] a, input logic [10:0] b, input logic [10:0] c);
    stream1 = a; stream2 = b; stream3 = c;
    desc_valid = 1'b1;
    step();
    desc_valid = 1'b0;
  endtask

  task automatic run_until(input int target, input int budget, input bit half, input string name);
    int cyc;
    cyc = 0;
    while (px_q.size() < target && cyc < budget) begin
      enable = half ? ~enable : 1'b1;
      step();
      cyc++;
    end
    enable = 1'b0;
    check(name, px_q.size() >= target, 1);
  endtask

  task automatic check_line(input int b, input vec_t v, input string name);
    int bad;
    bit e;
    bad = 0;
    for (int i = 0; i < 640; i++) begin
      e = (i >= v.first) && (i < v.first + v.nones);
      if (b + i >= px_q.size()) bad++;
      else if (px_q[b + i] != e) bad++;
    end
    check(name, bad, 0);
  endtask

  task automatic check_lerr(input int idx, input logic exp, input string name);
    check(name, (lerr_q.size() > idx) ? 32'(lerr_q[idx]) : 32'd2, 32'(exp));
  endtask

  initial begin
    vecs[0] = '{11'd100, 11'd200, 11'd340, 100, 200, 1'b0};
    vecs[1] = '{11'd639, 11'd0,   11'd0,   -1,  0,   1'b0};
    vecs[2] = '{11'd0,   11'd640, 11'd0,   0,   640, 1'b0};
    vecs[3] = '{11'd600, 11'd100, 11'd50,  600, 40,  1'b1};
    vecs[4] = '{11'd700, 11'd5,   11'd0,   -1,  0,   1'b1};
    vecs[5] = '{11'd0,   11'd0,   11'd640, -1,  0,   1'b0};
    vecs[6] = '{11'd639, 11'd5,   11'd0,   639, 1,   1'b1};
    vb      = '{11'd10,  11'd20,  11'd610, 10,  20,  1'b0};
    vfresh  = '{11'd50,  11'd60,  11'd530, 50,  60,  1'b0};

    step();
    step();
    check("rst_outs", {25'd0, pixelout, pix_valid, line_start, line_end, underrun, overflow, len_err}, 0);
    check("rst_ready", desc_ready, 1);
    RST = 1'b0;
    step();
    check("idle_no_pix", pix_valid, 0);

    enable = 1'b1;
    step();
    check("underrun_pulse", underrun, 1);
    check("underrun_no_pix", pix_valid, 0);
    enable = 1'b0;
    step();
    check("underrun_clear", underrun, 0);

    for (int k = 0; k < 7; k++) begin
      base = px_q.size();
      lb   = lerr_q.size();
      push(vecs[k].s1, vecs[k].s2, vecs[k].s3);
      run_until(base + 640, 700, 1'b0, $sformatf("v%0d_done", k));
      step();
      step();
      check_line(base, vecs[k], $sformatf("v%0d_pixels", k));
      check_lerr(lb, vecs[k].lerr, $sformatf("v%0d_len_err", k));
      check($sformatf("v%0d_hold", k), pixelout,
            32'((639 >= vecs[k].first) && (639 < vecs[k].first + vecs[k].nones)));
      check($sformatf("v%0d_idle", k), pix_valid, 0);
    end

    // Three descriptors while line A decodes: B fills the buffer, C is dropped.
    base = px_q.size();
    lb   = lerr_q.size();
    push(vecs[0].s1, vecs[0].s2, vecs[0].s3);
    stream1 = vb.s1; stream2 = vb.s2; stream3 = vb.s3;
    desc_valid = 1'b1;
    enable = 1'b1;
    step();
    stream1 = 11'd0; stream2 = 11'd640; stream3 = 11'd0;
    check("full_not_ready", desc_ready, 0);
    step();
    desc_valid = 1'b0;
    check("ovf_pulse", overflow, 1);
    step();
    check("ovf_clear", overflow, 0);
    run_until(base + 1280, 1400, 1'b0, "b2b_done");
    check_line(base, vecs[0], "b2b_line_a");
    check_line(base + 640, vb, "b2b_line_b");
    check_lerr(lb + 1, 1'b0, "b2b_len_err_b");
    enable = 1'b1;
    step();
    enable = 1'b0;
    check("dropped_desc_underrun", underrun, 1);
    step();

    // Half-rate enable gives the same pixel sequence.
    base = px_q.size();
    push(vecs[0].s1, vecs[0].s2, vecs[0].s3);
    run_until(base + 640, 1400, 1'b1, "half_done");
    step();
    check_line(base, vecs[0], "half_pixels");

    // Reset at pixel 300 with a second descriptor queued.
    base = px_q.size();
    push(vecs[0].s1, vecs[0].s2, vecs[0].s3);
    run_until(base + 300, 400, 1'b0, "mid_done");
    push(vb.s1, vb.s2, vb.s3);
    RST = 1'b1;
    #1;
    check("mid_rst_outs", {25'd0, pixelout, pix_valid, line_start, line_end, underrun, overflow, len_err}, 0);
    check("mid_rst_ready", desc_ready, 1);
    step();
    RST = 1'b0;
    enable = 1'b1;
    step();
    enable = 1'b0;
    check("flushed_underrun", underrun, 1);
    check("flushed_no_pix", pix_valid, 0);
    step();
    base = px_q.size();
    lb   = lerr_q.size();
    push(vfresh.s1, vfresh.s2, vfresh.s3);
    run_until(base + 640, 700, 1'b0, "fresh_done");
    step();
    check_line(base, vfresh, "fresh_pixels");
    check_lerr(lb, vfresh.lerr, "fresh_len_err");

    check("framing_flags", pos_bad, 0);
    check("valid_gaps", gap, 0);
    check("valid_without_enable", stray, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
